// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int WORD_W = 32;
  localparam int LEN_W  = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_LEN_HI  = 3'd2,
    ST_DATA    = 3'd3,
    ST_CHK     = 3'd4,
    ST_RELEASE = 3'd5,
    ST_RUN     = 3'd6,
    ST_ERROR   = 3'd7
  } state_e;

  // Running XOR over payload bytes.
  function automatic logic [BYTE_W-1:0] csum_update(input logic [BYTE_W-1:0] acc,
                                                    input logic [BYTE_W-1:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid pulses the
// cycle after the 4th byte of a word is strobed in.
module byte_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              strobe,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              word_last
);

  logic [1:0]        idx_q, idx_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;

  // Byte placement and word capture
  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear) begin
      idx_d   = 2'd0;
      shift_d = '0;
    end else if (strobe) begin
      case (idx_q)
        2'd0:    shift_d[7:0]   = byte_in;
        2'd1:    shift_d[15:8]  = byte_in;
        2'd2:    shift_d[23:16] = byte_in;
        2'd3:    shift_d[31:24] = byte_in;
        default: shift_d        = shift_q;
      endcase
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        word_d  = shift_d;
        valid_d = 1'b1;
      end else begin
        word_d  = word_q;
        valid_d = 1'b0;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= 2'd0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;
  assign word_last  = strobe && !clear && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader for instruction memory; holds the core in
// reset while loading. Optional checksum stage: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  byte_valid,
  input  logic [BYTE_W-1:0]     byte_data,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [WORD_W-1:0]     imem_wdata,
  output logic                  core_rst,
  output logic                  done,
  output logic                  err
);

  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            rel_cnt_q, rel_cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]     csum_q, csum_d;
`endif

  logic             xfer;
  logic             start;
  logic             asm_strobe;
  logic             asm_last;
  logic             last_word;
  logic [LEN_W-1:0] len_full;
  logic             oversize;

  assign xfer       = byte_valid && byte_ready;
  assign start      = load_start && (state_q inside {ST_IDLE, ST_RUN, ST_ERROR});
  assign asm_strobe = xfer && (state_q == ST_DATA);
  assign len_full   = {byte_data, len_q[7:0]};
  assign oversize   = {16'd0, len_full} > CAPACITY;
  // word_cnt_q still counts words before the one completing now
  assign last_word  = asm_last && (({1'b0, word_cnt_q} + 17'd1) == {1'b0, len_q});

  byte_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .strobe     (asm_strobe),
    .byte_in    (byte_data),
    .word       (imem_wdata),
    .word_valid (imem_we),
    .word_last  (asm_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RUN, ST_ERROR: begin
        if (load_start) state_d = ST_LEN_LO;
        else            state_d = state_q;
      end
      ST_LEN_LO: begin
        if (xfer) state_d = ST_LEN_HI;
        else      state_d = ST_LEN_LO;
      end
      ST_LEN_HI: begin
        if (!xfer)                   state_d = ST_LEN_HI;
        else if (len_full == 16'd0)  state_d = ST_RELEASE;
        else if (oversize)           state_d = ST_ERROR;
        else                         state_d = ST_DATA;
      end
      ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (last_word) state_d = ST_CHK;
        else           state_d = ST_DATA;
`else
        if (last_word) state_d = ST_RELEASE;
        else           state_d = ST_DATA;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (!xfer)                   state_d = ST_CHK;
        else if (byte_data == csum_q) state_d = ST_RELEASE;
        else                         state_d = ST_ERROR;
      end
`endif
      ST_RELEASE: begin
        if (rel_cnt_q == 8'd0) state_d = ST_RUN;
        else                   state_d = ST_RELEASE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    byte_ready = 1'b0;
    core_rst   = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_q)
      ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHK: byte_ready = 1'b1;
      ST_RUN: begin
        core_rst = 1'b1;
        done     = 1'b1;
      end
      ST_ERROR: err = 1'b1;
      default:  byte_ready = 1'b0;
    endcase
  end

  // Length capture, word counter, write address and release countdown
  always_comb begin
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    rel_cnt_d  = rel_cnt_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    if (start)           csum_d = 8'd0;
    else if (asm_strobe) csum_d = csum_update(csum_q, byte_data);
    else                 csum_d = csum_q;
`endif
    if (start) begin
      word_cnt_d = 16'd0;
    end else if (xfer && (state_q == ST_LEN_LO)) begin
      len_d[7:0] = byte_data;
    end else if (xfer && (state_q == ST_LEN_HI)) begin
      len_d[15:8] = byte_data;
    end else if (asm_last) begin
      word_cnt_d = word_cnt_q + 16'd1;
      addr_d     = ADDR_WIDTH'(word_cnt_q);
    end else begin
      len_d = len_q;
    end
    // Countdown is armed on the edge that enters RELEASE
    if ((state_d == ST_RELEASE) && (state_q != ST_RELEASE)) begin
      rel_cnt_d = 8'(RELEASE_DELAY - 1);
    end else if ((state_q == ST_RELEASE) && (rel_cnt_q != 8'd0)) begin
      rel_cnt_d = rel_cnt_q - 8'd1;
    end else begin
      rel_cnt_d = rel_cnt_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      rel_cnt_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      rel_cnt_q  <= rel_cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign imem_addr = addr_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a transaction-level model predicts every
// output each cycle; literal checks pin the model on known streams.
module tb_imem_loader;

  localparam int AW = 10;
  localparam int RD = 4;
  localparam int M_IDLE = 0, M_LOAD = 1, M_REL = 2, M_RUN = 3, M_ERR = 4;

  logic          clk = 1'b0;
  logic          rst, load_start, byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready, imem_we, core_rst, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  imem_loader #(.ADDR_WIDTH(AW), .RELEASE_DELAY(RD)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst(core_rst),
    .done(done), .err(err));

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0, lenhi_cyc = 0, last_we_cyc = 0, done_rise_cyc = 0, we_count = 0;
  logic [7:0]  stream[$];
  logic [31:0] mem[0:1023];

  // model state
  int          m_mode = M_IDLE, m_nacc = 0, m_rel = 0;
  bit          m_valid = 0, m_we = 0, m_after_rst = 0;
  logic [15:0] m_len = 16'd0;
  logic [7:0]  m_csum = 8'd0;
  logic [31:0] m_word = 32'd0, m_wdata = 32'd0;
  logic [AW-1:0] m_addr = '0;
  bit          prev_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model, advanced on each rising edge from the applied inputs
  initial forever begin
    int pos, p;
    @(posedge clk);
    m_we = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_addr = '0; m_wdata = 32'd0; m_valid = 1; m_after_rst = 1;
    end else begin
      m_after_rst = 0;
      case (m_mode)
        M_IDLE, M_RUN, M_ERR: if (load_start) begin
          m_mode = M_LOAD; m_nacc = 0; m_csum = 8'd0;
        end
        M_LOAD: if (byte_valid) begin
          pos = m_nacc;
          m_nacc++;
          if (pos == 0) m_len[7:0] = byte_data;
          else if (pos == 1) begin
            m_len[15:8] = byte_data;
            lenhi_cyc = cyc - 1;
            if (m_len == 16'd0) begin m_mode = M_REL; m_rel = RD; end
            else if (int'(m_len) > (1 << AW)) m_mode = M_ERR;
          end else if (pos - 2 < 4 * int'(m_len)) begin
            p = pos - 2;
            m_word[8*(p%4) +: 8] = byte_data;
            m_csum = m_csum ^ byte_data;
            if (p % 4 == 3) begin m_we = 1'b1; m_addr = AW'(p / 4); m_wdata = m_word; end
`ifndef IMEM_LOADER_CHECKSUM_EN
            if (p == 4 * int'(m_len) - 1) begin m_mode = M_REL; m_rel = RD; end
`endif
          end else begin
            if (byte_data == m_csum) begin m_mode = M_REL; m_rel = RD; end
            else m_mode = M_ERR;
          end
        end
        M_REL: begin
          m_rel--;
          if (m_rel == 0) m_mode = M_RUN;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // Compare process: every cycle, on the falling edge
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("byte_ready", {31'd0, byte_ready}, {31'd0, m_mode == M_LOAD});
      chk("imem_we",    {31'd0, imem_we},    {31'd0, m_we});
      chk("core_rst",   {31'd0, core_rst},   {31'd0, m_mode == M_RUN});
      chk("done",       {31'd0, done},       {31'd0, m_mode == M_RUN});
      chk("err",        {31'd0, err},        {31'd0, m_mode == M_ERR});
      if (m_we || m_after_rst) begin
        chk("imem_addr",  {22'd0, imem_addr}, {22'd0, m_addr});
        chk("imem_wdata", imem_wdata, m_wdata);
      end
      if (imem_we === 1'b1) begin
        mem[imem_addr] = imem_wdata; we_count++; last_we_cyc = cyc;
      end
      if (done === 1'b1 && !prev_done) done_rise_cyc = cyc;
      prev_done = (done === 1'b1);
    end
    cyc++;
  end

  task automatic push_len(input logic [15:0] n);
    stream.delete();
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) stream.push_back(w[8*i +: 8]);
  endtask

  task automatic finish_stream();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'd0;
    for (int i = 2; i < stream.size(); i++) x = x ^ stream[i];
    if (stream.size() > 2) stream.push_back(x);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      byte_valid = 1'($urandom); byte_data = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  // vmode: 0 full rate, 1 every other cycle, 2 random; abort_at: bytes before rst
  task automatic run_load(input int vmode, input int abort_at);
    bit fin, tog;
    fin = 0; tog = 0;
    load_start = 1'b1; byte_valid = 1'($urandom); byte_data = 8'($urandom);
    @(negedge clk);
    load_start = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      if (m_mode == M_RUN || m_mode == M_ERR) fin = 1;
      else if (abort_at >= 0 && m_mode == M_LOAD && m_nacc == abort_at) begin
        rst = 1'b1; byte_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0; fin = 1;
      end else begin
        tog = !tog;
        case (vmode)
          0:       byte_valid = 1'b1;
          1:       byte_valid = tog;
          default: byte_valid = 1'($urandom);
        endcase
        load_start = ($urandom_range(0, 9) == 0);
        byte_data  = (m_nacc < stream.size()) ? stream[m_nacc] : 8'($urandom);
        @(negedge clk);
        load_start = 1'b0;
      end
    end
    chk("load_finished", {31'd0, fin}, 32'd1);
    idle(3);
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_imem_we",    {31'd0, imem_we},    32'd0);
    chk("rst_imem_addr",  {22'd0, imem_addr},  32'd0);
    chk("rst_imem_wdata", imem_wdata,          32'd0);
    chk("rst_core_rst",   {31'd0, core_rst},   32'd0);
    chk("rst_done",       {31'd0, done},       32'd0);
    chk("rst_err",        {31'd0, err},        32'd0);
    rst = 1'b0;
    idle(2);

    // two words at full rate
    push_len(16'd2); push_word(32'h00A00513); push_word(32'h00B00593); finish_stream();
    run_load(0, -1);
    chk("t1_mem0", mem[0], 32'h00A00513);
    chk("t1_mem1", mem[1], 32'h00B00593);
    chk("t1_done", {31'd0, done}, 32'd1);
`ifndef IMEM_LOADER_CHECKSUM_EN
    chk("t1_release_delay", done_rise_cyc - last_we_cyc, RD);
`endif

    // same stream, byte_valid every other cycle
    mem[0] = 32'd0; mem[1] = 32'd0;
    run_load(1, -1);
    chk("t2_mem0", mem[0], 32'h00A00513);
    chk("t2_mem1", mem[1], 32'h00B00593);

    // empty program
    begin
      int wb;
      wb = we_count;
      push_len(16'd0);
      run_load(2, -1);
      chk("t3_no_write", we_count - wb, 32'd0);
      chk("t3_release_delay", done_rise_cyc - lenhi_cyc, RD + 1);
    end

    // oversize length, then recovery
    push_len(16'h0401); stream.push_back(8'hAA); stream.push_back(8'h55);
    run_load(0, -1);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("t4_core_rst", {31'd0, core_rst}, 32'd0);
    push_len(16'd2); push_word(32'h00A00513); push_word(32'h00B00593); finish_stream();
    run_load(2, -1);
    chk("t4_recover_done", {31'd0, done}, 32'd1);

    // reset after six payload bytes, then reload from address 0
    push_len(16'd2); push_word(32'h11111111); push_word(32'h22222222); finish_stream();
    run_load(0, 8);
    chk("t5_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_mem1_kept", mem[1], 32'h00B00593);
    push_len(16'd1); push_word(32'hDEADBEEF); finish_stream();
    run_load(1, -1);
    chk("t5_mem0", mem[0], 32'hDEADBEEF);
    chk("t5_mem1_still", mem[1], 32'h00B00593);

`ifdef IMEM_LOADER_CHECKSUM_EN
    push_len(16'd1); push_word(32'h44332211); stream.push_back(8'h44);
    run_load(0, -1);
    chk("ck_good_done", {31'd0, done}, 32'd1);
    push_len(16'd1); push_word(32'h44332211); stream.push_back(8'h45);
    run_load(0, -1);
    chk("ck_bad_err", {31'd0, err}, 32'd1);
    chk("ck_bad_core_rst", {31'd0, core_rst}, 32'd0);
    chk("ck_bad_mem0", mem[0], 32'h44332211);
`endif

    // randomized loads
    for (int r = 0; r < 24; r++) begin
      int n;
      n = $urandom_range(0, 5);
      push_len(16'(n));
      for (int w = 0; w < n; w++) push_word($urandom);
      finish_stream();
      run_load($urandom_range(0, 2), ($urandom_range(0, 7) == 0) ? 2 + $urandom_range(0, 4 * n) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
